// File: rtl/stage2.sv
// Execute stage: registers stage-1 operands/control, runs the ALU, and forwards
// stage 3's pending write-back at both capture time (distance 2) and execute time (distance 1).
module stage2 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] S1_ReadData1,
    input  logic [31:0] S1_ReadData2,
    input  logic [4:0]  S1_ReadSelect1,
    input  logic [4:0]  S1_ReadSelect2,
    input  logic [15:0] S1_Imm,
    input  logic        S1_DataSource,
    input  logic [2:0]  S1_ALUOp,
    input  logic [4:0]  S1_WriteSelect,
    input  logic        S1_WriteEnable,
    input  logic [31:0] S3_out,
    input  logic [4:0]  S3_WriteSelect,
    input  logic        S3_WriteEnable,
    output logic [31:0] ALU_out,
    output logic [4:0]  S2_WriteSelect,
    output logic        S2_WriteEnable
);

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    logic [31:0] s1_read_data   [2];
    logic [4:0]  s1_read_select [2];
    logic [31:0] operand_next   [2];
    logic [31:0] operand_reg    [2];
    logic [4:0]  rs_reg         [2];
    logic [31:0] operand_fwd    [2];

    logic [31:0] imm_reg;
    logic        data_source_reg;
    logic [2:0]  alu_op_reg;
    logic [31:0] alu_a;
    logic [31:0] alu_b;

    assign s1_read_data[0]   = S1_ReadData1;
    assign s1_read_data[1]   = S1_ReadData2;
    assign s1_read_select[0] = S1_ReadSelect1;
    assign s1_read_select[1] = S1_ReadSelect2;

    // Per read port: capture-time forward for the incoming instruction and
    // execute-time forward for the one already held here. r0 never forwards.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic capture_hit;
            logic execute_hit;

            assign capture_hit = S3_WriteEnable && (s1_read_select[gi] != 5'd0)
                              && (S3_WriteSelect == s1_read_select[gi]);
            assign execute_hit = S3_WriteEnable && (rs_reg[gi] != 5'd0)
                              && (S3_WriteSelect == rs_reg[gi]);

            assign operand_next[gi] = capture_hit ? S3_out : s1_read_data[gi];
            assign operand_fwd[gi]  = execute_hit ? S3_out : operand_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                operand_reg[i] <= '0;
                rs_reg[i]      <= '0;
            end
            imm_reg         <= '0;
            data_source_reg <= 1'b0;
            alu_op_reg      <= OP_MOV;
            S2_WriteSelect  <= '0;
            S2_WriteEnable  <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                operand_reg[i] <= operand_next[i];
                rs_reg[i]      <= s1_read_select[i];
            end
            imm_reg         <= {{16{S1_Imm[15]}}, S1_Imm};
            data_source_reg <= S1_DataSource;
            alu_op_reg      <= S1_ALUOp;
            S2_WriteSelect  <= S1_WriteSelect;
            S2_WriteEnable  <= S1_WriteEnable;
        end
    end

    // The immediate bypasses forwarding entirely.
    assign alu_a = operand_fwd[0];
    assign alu_b = data_source_reg ? imm_reg : operand_fwd[1];

    always_comb begin
        ALU_out = '0;
        case (alu_op_reg)
            OP_MOV:  ALU_out = alu_b;
            OP_NOT:  ALU_out = ~alu_a;
            OP_ADD:  ALU_out = alu_a + alu_b;
            OP_SUB:  ALU_out = alu_a - alu_b;
            OP_OR:   ALU_out = alu_a | alu_b;
            OP_AND:  ALU_out = alu_a & alu_b;
            OP_SLT:  ALU_out = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            OP_NOP:  ALU_out = '0;
            default: ALU_out = '0;
        endcase
    end

endmodule
